// File: rtl/fsk_frame_sequencer_pkg.sv
// Shared definitions for the FSK modulation control blocks.
// Provides the sequencer state encoding and the frame-shape constants
// (symbol count, start/stop bit levels, minimum symbol length, divider width).
package fsk_frame_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SYM  = 1'b1
  } fsk_state_e;

  localparam int   FRAME_SYMS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   MIN_SYM    = 2;
  localparam int   DIV_W      = 9;

  localparam logic [3:0] LAST_SYM_IDX = 4'(FRAME_SYMS - 1);

endpackage

// File: rtl/fsk_sym_timer.sv
// Symbol-length timer for the FSK frame sequencer.
// Counts 0..N-1 clock cycles per symbol, where N = max(sym_cycles, MIN_SYM)
// is captured on load. Strobes mark the first and last cycle of a symbol.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture sym_cycles and restart the count at 0
//   clear        return the count to 0 (length register kept)
//   run          advance the count; wraps to 0 after the last cycle
//   sym_cycles   requested symbol length in clock cycles
//   sym_first    count is on the first cycle of a symbol
//   sym_last     count is on the last cycle of a symbol
module fsk_sym_timer #(
  parameter int SYM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             run,
  input  logic [SYM_W-1:0] sym_cycles,
  output logic             sym_first,
  output logic             sym_last
);
  import fsk_frame_sequencer_pkg::*;

  logic [SYM_W-1:0] cnt_q;
  logic [SYM_W-1:0] last_q;
  logic [SYM_W-1:0] len_m1;

  // Clamp so every symbol has at least one cycle with the divider running.
  assign len_m1 = (sym_cycles < SYM_W'(MIN_SYM)) ? SYM_W'(MIN_SYM - 1)
                                                 : sym_cycles - SYM_W'(1);

  assign sym_first = (cnt_q == '0);
  assign sym_last  = (cnt_q == last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      last_q <= len_m1;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= sym_last ? '0 : cnt_q + SYM_W'(1);
    end
  end

endmodule

// File: rtl/fsk_frame_sequencer.sv
// FSK frame sequencer: turns bytes into a UART-style symbol stream
// (start 0, 8 data bits LSB first, stop 1) for a load-to-511 toggle divider.
// Each symbol loads the divider with the mark or space tone on its first
// cycle and lets it free-run for the remaining N-1 cycles.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      byte available
//   in_data       byte to transmit
//   in_ready      byte accepted when in_valid & in_ready
//   mark_load     divider load for a 1 bit
//   space_load    divider load for a 0 bit
//   sym_cycles    clock cycles per symbol (clamped to at least 2)
//   div_init      divider init (1 = load / hold)
//   div_cnt_ext   divider load value
//   tx_bit        logical bit being sent
//   busy          frame in progress
//   frame_done    one-cycle pulse after the stop symbol
//
// state   | meaning
// ST_IDLE | divider held in init with mark tone, waiting for a byte
// ST_SYM  | sending symbol idx_q of the current frame
module fsk_frame_sequencer #(
  parameter int DATA_W = 8,
  parameter int SYM_W  = 16,
  parameter int DIV_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DIV_W-1:0]  mark_load,
  input  logic [DIV_W-1:0]  space_load,
  input  logic [SYM_W-1:0]  sym_cycles,
  output logic              div_init,
  output logic [DIV_W-1:0]  div_cnt_ext,
  output logic              tx_bit,
  output logic              busy,
  output logic              frame_done
);
  import fsk_frame_sequencer_pkg::*;

  fsk_state_e        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0]  mark_q, mark_d;
  logic [DIV_W-1:0]  space_q, space_d;
  logic              init_q, init_d;
  logic [DIV_W-1:0]  ext_q, ext_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              nxt_bit;

  logic sym_first, sym_last;
  logic t_load, t_clear, t_run;
  logic frame_end, accept;

  fsk_sym_timer #(.SYM_W(SYM_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (t_load),
    .clear      (t_clear),
    .run        (t_run),
    .sym_cycles (sym_cycles),
    .sym_first  (sym_first),
    .sym_last   (sym_last)
  );

  assign frame_end = (state_q == ST_SYM) && sym_last && (idx_q == LAST_SYM_IDX);
  // Ready depends only on registered state so the source can't form a loop.
  assign in_ready  = ~rst & ((state_q == ST_IDLE) | frame_end);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    mark_d  = mark_q;
    space_d = space_q;
    init_d  = init_q;
    ext_d   = ext_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_run   = 1'b0;
    nxt_bit = STOP_BIT;

    case (state_q)
      ST_IDLE: begin
        init_d = 1'b1;
        ext_d  = mark_load;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      ST_SYM: begin
        t_run = 1'b1;
        if (sym_first) init_d = 1'b0;
        if (sym_last) begin
          if (idx_q == LAST_SYM_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            t_clear = 1'b1;
            init_d  = 1'b1;
            ext_d   = mark_load;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            // Symbol idx_q+1: data bits come from the shifter, the last is stop.
            nxt_bit = (idx_q == LAST_SYM_IDX - 4'd1) ? STOP_BIT : sh_q[0];
            sh_d    = sh_q >> 1;
            idx_d   = idx_q + 4'd1;
            init_d  = 1'b1;
            ext_d   = nxt_bit ? mark_q : space_q;
            tx_d    = nxt_bit;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new byte (from IDLE or on the last stop cycle) starts the start symbol
    // directly from the live inputs, which are also the snapshot values.
    if (accept) begin
      state_d = ST_SYM;
      idx_d   = 4'd0;
      sh_d    = in_data;
      mark_d  = mark_load;
      space_d = space_load;
      t_load  = 1'b1;
      t_clear = 1'b0;
      init_d  = 1'b1;
      ext_d   = START_BIT ? mark_load : space_load;
      tx_d    = START_BIT;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      sh_q    <= '0;
      mark_q  <= '0;
      space_q <= '0;
      init_q  <= 1'b1;
      ext_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      mark_q  <= mark_d;
      space_q <= space_d;
      init_q  <= init_d;
      ext_q   <= ext_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign div_init    = init_q;
  assign div_cnt_ext = ext_q;
  assign tx_bit      = tx_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_fsk_frame_sequencer.sv
// Self-checking bench for fsk_frame_sequencer: a model process predicts each
// accepted frame's symbols and frame_done cycle into queues; a monitor process
// pops and compares them as the DUT presents symbols.
module tb_fsk_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [8:0]  mark_load;
  logic [8:0]  space_load;
  logic [15:0] sym_cycles;
  logic        div_init;
  logic [8:0]  div_cnt_ext;
  logic        tx_bit;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [8:0] ext;
    logic       bit_v;
    int         n;
  } sym_t;

  sym_t        sym_q[$];
  int unsigned done_q[$];
  int unsigned ready_from = 0;

  fsk_frame_sequencer #(.DATA_W(8), .SYM_W(16), .DIV_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mark_load   (mark_load),
    .space_load  (space_load),
    .sym_cycles  (sym_cycles),
    .div_init    (div_init),
    .div_cnt_ext (div_cnt_ext),
    .tx_bit      (tx_bit),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference model: frame = start 0, data LSB first, stop 1; N = max(sym,2);
  // busy for 10N cycles after accept, ready again on the last of them.
  always @(negedge clk) begin
    sym_t s;
    int   n;
    if (rst) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
      sym_q.delete();
      done_q.delete();
      ready_from = cyc;
    end else begin
      chk("in_ready", int'(in_ready), (cyc >= ready_from) ? 1 : 0);
      if (in_valid && in_ready) begin
        n = (sym_cycles < 16'd2) ? 2 : int'(sym_cycles);
        for (int k = 0; k < 10; k++) begin
          if (k == 0)      s.bit_v = 1'b0;
          else if (k == 9) s.bit_v = 1'b1;
          else             s.bit_v = in_data[k-1];
          s.ext = s.bit_v ? mark_load : space_load;
          s.n   = n;
          sym_q.push_back(s);
        end
        done_q.push_back(cyc + 10 * n + 1);
        ready_from = cyc + 10 * n;
      end
    end
  end

  // Monitor: pops a symbol on every init pulse while busy and checks its hold.
  logic       rst_d = 1'b0;
  logic [8:0] mark_d = '0;
  int         remaining = 0;
  logic [8:0] held_ext = '0;
  logic       held_bit = 1'b0;

  always @(negedge clk) begin
    sym_t s;
    if (rst_d) begin
      chk("rst_div_init", int'(div_init), 1);
      chk("rst_div_cnt_ext", int'(div_cnt_ext), 0);
      chk("rst_tx_bit", int'(tx_bit), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      remaining = 0;
    end else if (!rst) begin
      if (frame_done) begin
        if (done_q.size() == 0) fail("frame_done_unexpected");
        else chk("frame_done_cycle", int'(cyc), int'(done_q.pop_front()));
      end
      if (busy && div_init) begin
        chk("sym_too_short", remaining, 0);
        if (sym_q.size() == 0) fail("symbol_unexpected");
        else begin
          s = sym_q.pop_front();
          chk("sym_div_cnt_ext", int'(div_cnt_ext), int'(s.ext));
          chk("sym_tx_bit", int'(tx_bit), int'(s.bit_v));
          remaining = s.n - 1;
          held_ext  = s.ext;
          held_bit  = s.bit_v;
        end
      end else if (busy) begin
        if (remaining == 0) fail("sym_too_long");
        else begin
          remaining--;
          chk("hold_div_cnt_ext", int'(div_cnt_ext), int'(held_ext));
          chk("hold_tx_bit", int'(tx_bit), int'(held_bit));
        end
      end else begin
        chk("idle_sym_cut_short", remaining, 0);
        remaining = 0;
        chk("idle_div_init", int'(div_init), 1);
        chk("idle_tx_bit", int'(tx_bit), 1);
        chk("idle_div_cnt_ext", int'(div_cnt_ext), int'(mark_d));
      end
    end
    rst_d  = rst;
    mark_d = mark_load;
  end

  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
    end
    if (!ok) fail("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 5000) fail("idle_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    mark_load  = 9'd500;
    space_load = 9'd480;
    sym_cycles = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // single frame
    send(8'hA5);
    wait_idle();

    // back-to-back with in_valid held
    send(8'h00);
    send(8'hFF);
    wait_idle();

    // clamp
    sym_cycles = 16'd0;
    send(8'h3C);
    wait_idle();
    sym_cycles = 16'd1;
    send(8'hC3);
    wait_idle();

    // inputs changed mid-frame must not affect the frame in flight
    sym_cycles = 16'd4;
    mark_load  = 9'd500;
    send(8'h5A);
    repeat (9) @(posedge clk);
    #1;
    mark_load  = 9'd100;
    sym_cycles = 16'd8;
    wait_idle();
    @(negedge clk);
    chk("idle_after_snapshot_mark", int'(div_cnt_ext), 100);
    @(posedge clk);
    #1;

    // reset mid-frame
    mark_load  = 9'd500;
    sym_cycles = 16'd4;
    send(8'h81);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(8'h96);
    wait_idle();

    // randomized frames, sometimes back-to-back
    for (int f = 0; f < 20; f++) begin
      mark_load  = 9'($urandom_range(0, 510));
      space_load = 9'($urandom_range(0, 510));
      sym_cycles = 16'($urandom_range(0, 6));
      send(8'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    chk("symbols_left_over", sym_q.size(), 0);
    chk("frame_done_missing", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
